// File: rtl/mdc_sink_pkg.sv
// Shared types and default sizing for the dataflow stream sink.
package mdc_sink_pkg;

    localparam int unsigned MDC_DATA_WIDTH = 32;
    localparam int unsigned MDC_DEPTH      = 4;
    localparam int unsigned MDC_LEN_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sink_state_t;

endpackage

// File: rtl/mdc_sink_fifo.sv
// Registered circular buffer with read/write pointers and occupancy count.
module mdc_sink_fifo import mdc_sink_pkg::*; #(
    parameter int unsigned DATA_WIDTH = MDC_DATA_WIDTH,
    parameter int unsigned DEPTH      = MDC_DEPTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic                  full
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  do_push;
    logic                  do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CW'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mdc_stream_sink.sv
// Frame-oriented sink: buffers a producer stream of len words toward a streamer.
module mdc_stream_sink import mdc_sink_pkg::*; #(
    parameter int unsigned DATA_WIDTH = MDC_DATA_WIDTH,
    parameter int unsigned DEPTH      = MDC_DEPTH,
    parameter int unsigned LEN_WIDTH  = MDC_LEN_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_wr,
    output logic                  in_full,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    sink_state_t           state_q;
    sink_state_t           state_d;
    logic [LEN_WIDTH-1:0]  len_q;
    logic [LEN_WIDTH-1:0]  wr_cnt;
    logic [LEN_WIDTH-1:0]  rd_cnt;
    logic                  overflow_q;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  accept;
    logic                  xfer;
    logic                  start_acc;

    mdc_sink_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (accept),
        .push_data (in_data),
        .pop       (xfer),
        .pop_data  (fifo_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Outputs are gated by reset so they read idle while reset is held.
    assign out_valid = reset && !fifo_empty;
    assign out_data  = reset ? fifo_data : '0;
    assign out_last  = out_valid && (rd_cnt == len_q - LEN_WIDTH'(1));
    assign xfer      = out_valid && out_ready;
    assign overflow  = reset && overflow_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_full   = 1'b1;
        busy      = 1'b0;
        done      = 1'b0;
        accept    = 1'b0;
        start_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_d   = (len == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy    = 1'b1;
                in_full = fifo_full;
                accept  = in_wr && !fifo_full;
                if (accept && (wr_cnt + LEN_WIDTH'(1) == len_q)) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (xfer && out_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!reset) begin
            in_full   = 1'b1;
            busy      = 1'b0;
            done      = 1'b0;
            accept    = 1'b0;
            start_acc = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            len_q      <= '0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (start_acc) begin
                len_q  <= len;
                wr_cnt <= '0;
                rd_cnt <= '0;
            end else begin
                if (accept) begin
                    wr_cnt <= wr_cnt + LEN_WIDTH'(1);
                end
                if (xfer) begin
                    rd_cnt <= rd_cnt + LEN_WIDTH'(1);
                end
            end
            if (in_wr && in_full) begin
                overflow_q <= 1'b1;
            end else if (start_acc) begin
                overflow_q <= 1'b0;
            end
        end
    end

endmodule
